// File: rtl/fprint_sender_if.sv
// rtl/fprint_sender_if.sv - request and Avalon-MM write interfaces for fprint_sender

interface fprint_req_if;
    logic        req_valid;
    logic [1:0]  req_type;
    logic [3:0]  req_task_id;
    logic [31:0] req_crc;
    logic        req_ready;

    modport master (output req_valid, req_type, req_task_id, req_crc, input req_ready);
    modport slave  (input req_valid, req_type, req_task_id, req_crc, output req_ready);
endinterface

interface fprint_avmm_if;
    logic [7:0]  fprint_address;
    logic        fprint_write;
    logic [31:0] fprint_writedata;
    logic        fprint_waitrequest;

    modport master (output fprint_address, fprint_write, fprint_writedata, input fprint_waitrequest);
    modport slave  (input fprint_address, fprint_write, fprint_writedata, output fprint_waitrequest);
endinterface

// File: rtl/fprint_sender.sv
// rtl/fprint_sender.sv - buffers fingerprint requests and issues comparator Avalon writes
// Optional saturating drop counter: define FPRINT_SENDER_DROP_CNT_EN.

module fprint_sender #(
    parameter logic [3:0] CORE_ID    = 4'd0,
    parameter logic [3:0] CS_OFFSET  = 4'd0,
    parameter logic [3:0] CRC_OFFSET = 4'd1,
    parameter int         FIFO_AW    = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    fprint_req_if.slave   req,
    fprint_avmm_if.master fprint,
    output logic          busy,
    output logic [15:0]   drop_count
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_LATCH,
        ST_WR0,
        ST_WR1
    } state_t;

    state_t state, state_nxt;

    logic [37:0]      mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr, rd_ptr;
    logic [37:0]      rd_data;
    logic             fifo_full, fifo_empty;
    logic             wr_en, rd_en;

    logic             hold_ld;
    logic             hold_fp;
    logic [3:0]       hold_task;
    logic [15:0]      hold_crc_hi;

    logic [7:0]       addr_nxt;
    logic [31:0]      data_nxt;
    logic             write_nxt;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                        (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign wr_en      = req.req_valid && !fifo_full && (req.req_type != 2'b11);
    assign req.req_ready = !fifo_full;
    assign busy       = !fifo_empty || (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= {req.req_type, req.req_task_id, req.req_crc};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr[FIFO_AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                   <= ST_IDLE;
            hold_fp                 <= 1'b0;
            hold_task               <= '0;
            hold_crc_hi             <= '0;
            fprint.fprint_address   <= '0;
            fprint.fprint_writedata <= '0;
            fprint.fprint_write     <= 1'b0;
        end else begin
            state                   <= state_nxt;
            fprint.fprint_address   <= addr_nxt;
            fprint.fprint_writedata <= data_nxt;
            fprint.fprint_write     <= write_nxt;
            if (hold_ld) begin
                hold_fp     <= (rd_data[37:36] == 2'b10);
                hold_task   <= rd_data[35:32];
                hold_crc_hi <= rd_data[31:16];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        hold_ld   = 1'b0;
        addr_nxt  = fprint.fprint_address;
        data_nxt  = fprint.fprint_writedata;
        write_nxt = fprint.fprint_write;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = ST_POP;
                end
            end
            ST_POP: begin
                rd_en     = 1'b1;
                state_nxt = ST_LATCH;
            end
            ST_LATCH: begin
                // First beat is built straight from the FIFO output so it is registered on entry to ST_WR0.
                hold_ld   = 1'b1;
                write_nxt = 1'b1;
                state_nxt = ST_WR0;
                if (rd_data[37:36] == 2'b10) begin
                    addr_nxt = {CORE_ID, CRC_OFFSET};
                    data_nxt = {rd_data[15:0], 10'h0, 1'b0, 1'b0, rd_data[35:32]};
                end else begin
                    addr_nxt = {CORE_ID, CS_OFFSET};
                    data_nxt = {16'h0, 10'h0, 1'b0, (rd_data[37:36] == 2'b00), rd_data[35:32]};
                end
            end
            ST_WR0: begin
                if (!fprint.fprint_waitrequest) begin
                    write_nxt = 1'b0;
                    state_nxt = hold_fp ? ST_WR1 : ST_IDLE;
                end
            end
            ST_WR1: begin
                // Arrives with write low: that cycle is the mandatory gap before the hi beat.
                if (!fprint.fprint_write) begin
                    write_nxt = 1'b1;
                    addr_nxt  = {CORE_ID, CRC_OFFSET};
                    data_nxt  = {hold_crc_hi, 10'h0, 1'b1, 1'b0, hold_task};
                end else if (!fprint.fprint_waitrequest) begin
                    write_nxt = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                write_nxt = 1'b0;
            end
        endcase
    end

`ifdef FPRINT_SENDER_DROP_CNT_EN
    logic [15:0] drop_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_q <= '0;
        end else if (req.req_valid && !wr_en && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_count = drop_q;
`else
    assign drop_count = 16'h0;
`endif

endmodule

// File: tb/tb_fprint_sender.sv
// tb/tb_fprint_sender.sv - randomized self-checking bench for fprint_sender (CORE_ID=3)

module tb_fprint_sender;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        busy;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    fprint_req_if  rq ();
    fprint_avmm_if av ();

    fprint_sender #(
        .CORE_ID   (4'd3),
        .CS_OFFSET (4'd0),
        .CRC_OFFSET(4'd1),
        .FIFO_AW   (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (rq.slave),
        .fprint    (av.master),
        .busy      (busy),
        .drop_count(drop_count)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [40:0] exp_q[$];
    int          outstanding = 0;
    logic [15:0] exp_drop = 16'h0;
    bit          mon_en = 1'b0;
    bit          prev_acc = 1'b0;
    bit          prev_hold = 1'b0;
    logic [7:0]  prev_addr, last_addr;
    logic [31:0] prev_data, last_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: each accepted request yields one CS write or two CRC writes, lo then hi.
    task automatic model_push(input logic [1:0] t, input logic [3:0] id, input logic [31:0] crc);
        logic [31:0] lo, hi, cs;
        lo = ((crc & 32'h0000_FFFF) << 16) + 32'(id);
        hi = ((crc >> 16) << 16) + 32'h20 + 32'(id);
        cs = ((t == 2'b00) ? 32'h10 : 32'h0) + 32'(id);
        outstanding++;
        if (t == 2'b10) begin
            exp_q.push_back({1'b0, 8'h31, lo});
            exp_q.push_back({1'b1, 8'h31, hi});
        end else begin
            exp_q.push_back({1'b1, 8'h30, cs});
        end
    endtask

    task automatic count_drop();
`ifdef FPRINT_SENDER_DROP_CNT_EN
        if (exp_drop != 16'hFFFF) exp_drop++;
`endif
    endtask

    task automatic send(input logic [1:0] t, input logic [3:0] id, input logic [31:0] crc,
                        input logic exp_rdy);
        rq.req_valid   = 1'b1;
        rq.req_type    = t;
        rq.req_task_id = id;
        rq.req_crc     = crc;
        @(negedge clk);
        check("req_ready", rq.req_ready, exp_rdy);
        if (exp_rdy && t != 2'b11) model_push(t, id, crc);
        else count_drop();
        @(posedge clk);
        #1;
        rq.req_valid = 1'b0;
    endtask

    task automatic wait_write();
        int n = 0;
        while (!av.fprint_write && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("write_seen", av.fprint_write, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        av.fprint_waitrequest = 1'b0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_queue", exp_q.size(), 0);
        check("drain_busy", busy, 1'b0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            logic [40:0] e;
            if (prev_hold) begin
                check("hold_write", av.fprint_write, 1'b1);
                check("hold_addr", av.fprint_address, prev_addr);
                check("hold_data", av.fprint_writedata, prev_data);
            end
            if (prev_acc) check("write_gap", av.fprint_write, 1'b0);
            prev_acc  = av.fprint_write && !av.fprint_waitrequest;
            prev_hold = av.fprint_write && av.fprint_waitrequest;
            prev_addr = av.fprint_address;
            prev_data = av.fprint_writedata;
            if (prev_acc) begin
                check("write_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", av.fprint_address, e[39:32]);
                    check("wr_data", av.fprint_writedata, e[31:0]);
                    if (e[40]) outstanding--;
                end
                last_addr = av.fprint_address;
                last_data = av.fprint_writedata;
            end
        end
    end

    initial begin
        int          lat;
        logic [1:0]  t;
        logic [31:0] c;

        rq.req_valid = 1'b0;
        rq.req_type = 2'b00;
        rq.req_task_id = 4'h0;
        rq.req_crc = 32'h0;
        av.fprint_waitrequest = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_write", av.fprint_write, 1'b0);
        check("rst_addr", av.fprint_address, 8'h00);
        check("rst_data", av.fprint_writedata, 32'h0);
        check("rst_ready", rq.req_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_drop", drop_count, 16'h0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        @(posedge clk);
        #1;

        // Checkout task 5 with first-write latency measured from the request cycle.
        send(2'b00, 4'd5, 32'h0, 1'b1);
        lat = 1;
        while (!av.fprint_write && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("latency", lat, 4);
        drain();
        check("co_addr", last_addr, 8'h30);
        check("co_data", last_data, 32'h0000_0015);

        send(2'b10, 4'd2, 32'hDEAD_BEEF, 1'b1);
        drain();
        check("fp_hi_addr", last_addr, 8'h31);
        check("fp_hi_data", last_data, 32'hDEAD_0022);

        // Waitrequest stall in ST_WR0.
        av.fprint_waitrequest = 1'b1;
        send(2'b01, 4'd4, 32'h0, 1'b1);
        wait_write();
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("stall_write", av.fprint_write, 1'b1);
        check("stall_addr", av.fprint_address, 8'h30);
        check("stall_data", av.fprint_writedata, 32'h0000_0004);
        @(posedge clk);
        #1;
        drain();

        // Illegal type is never queued.
        send(2'b11, 4'd6, 32'h1234_5678, 1'b1);
        repeat (4) begin
            @(negedge clk);
            check("illegal_busy", busy, 1'b0);
        end
        check("illegal_drop", drop_count, exp_drop);
        @(posedge clk);
        #1;

        // Fill: one request parked in ST_WR0, then four fill the FIFO and a fifth is refused.
        av.fprint_waitrequest = 1'b1;
        send(2'b00, 4'd1, 32'h0, 1'b1);
        wait_write();
        @(posedge clk);
        #1;
        send(2'b10, 4'd10, 32'hCAFE_F00D, 1'b1);
        send(2'b01, 4'd11, 32'h0, 1'b1);
        send(2'b00, 4'd12, 32'h0, 1'b1);
        send(2'b10, 4'd13, 32'h0123_4567, 1'b1);
        send(2'b00, 4'd14, 32'h0, 1'b0);
        check("full_busy", busy, 1'b1);
        check("full_drop", drop_count, exp_drop);
        drain();

        // Randomized traffic with random waitrequest.
        for (int i = 0; i < 400; i++) begin
            av.fprint_waitrequest = ($urandom_range(0, 3) == 0);
            if (outstanding < 4 && $urandom_range(0, 2) != 0) begin
                t = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                c = $urandom;
                send(t, 4'($urandom_range(0, 15)), c, 1'b1);
            end else begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        check("rand_drop", drop_count, exp_drop);

        // Reset asserted while the hi half is stalled in ST_WR1.
        send(2'b10, 4'd7, 32'hA5A5_5A5A, 1'b1);
        wait_write();
        @(posedge clk);
        #1;
        av.fprint_waitrequest = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("wr1_write", av.fprint_write, 1'b1);
        check("wr1_pending", exp_q.size(), 1);
        #2;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check("arst_write", av.fprint_write, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_ready", rq.req_ready, 1'b1);
        check("arst_drop", drop_count, 16'h0);
        exp_q.delete();
        outstanding = 0;
        exp_drop = 16'h0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        av.fprint_waitrequest = 1'b0;
        prev_acc  = 1'b0;
        prev_hold = 1'b0;
        mon_en    = 1'b1;
        send(2'b00, 4'd9, 32'h0, 1'b1);
        drain();
        check("post_rst_addr", last_addr, 8'h30);
        check("post_rst_data", last_data, 32'h0000_0019);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
